// File: rtl/frame_seq_sc.sv
// Frame sequencer ahead of the one-hot handshake plug: skip / pass / pad phases per start.
// Optional FRAME_SEQ_SC_CNT_EN adds frame_cnt and drop_cnt status counters.
module frame_seq_sc #(
  parameter int unsigned    DW        = 32,
  parameter int unsigned    LW        = 16,
  parameter logic [DW-1:0]  PAD_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] skip_len,
  input  logic [LW-1:0] pass_len,
  input  logic [LW-1:0] pad_len,
  input  logic          ivalid,
  input  logic          iready,
  input  logic          ovalid,
  input  logic          oready,
  input  logic [DW-1:0] idata,
  output logic [3:0]    state,
  output logic [DW-1:0] odata,
  output logic          busy,
`ifdef FRAME_SEQ_SC_CNT_EN
  output logic          done,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   drop_cnt
`else
  output logic          done
`endif
);

  typedef enum logic [3:0] {
    FILL = 4'b0001,
    PASS = 4'b0010,
    PAD  = 4'b0100,
    WAIT = 4'b1000
  } state_t;

  state_t        st, st_next;
  logic [LW-1:0] cnt, cnt_next;
  logic [LW-1:0] skip_q, pass_q, pad_q;
  logic [LW-1:0] skip_next, pass_next, pad_next;
  logic          done_q, done_next;
  logic          in_hs, out_hs;

  assign in_hs  = ivalid & iready;
  assign out_hs = ovalid & oready;

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= WAIT;
      cnt    <= '0;
      skip_q <= '0;
      pass_q <= '0;
      pad_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st     <= st_next;
      cnt    <= cnt_next;
      skip_q <= skip_next;
      pass_q <= pass_next;
      pad_q  <= pad_next;
      done_q <= done_next;
    end
  end

  always_comb begin
    st_next   = st;
    cnt_next  = cnt;
    skip_next = skip_q;
    pass_next = pass_q;
    pad_next  = pad_q;
    done_next = 1'b0;
    unique case (st)
      WAIT: begin
        if (start) begin
          skip_next = skip_len;
          pass_next = pass_len;
          pad_next  = pad_len;
          cnt_next  = '0;
          // An all-zero frame completes immediately without leaving WAIT
          if (skip_len != '0)      st_next = FILL;
          else if (pass_len != '0) st_next = PASS;
          else if (pad_len != '0)  st_next = PAD;
          else                     done_next = 1'b1;
        end
      end
      FILL: begin
        if (in_hs) begin
          if (cnt == skip_q - LW'(1)) begin
            cnt_next = '0;
            if (pass_q != '0)     st_next = PASS;
            else if (pad_q != '0) st_next = PAD;
            else begin
              st_next   = WAIT;
              done_next = 1'b1;
            end
          end else begin
            cnt_next = cnt + LW'(1);
          end
        end
      end
      PASS: begin
        if (out_hs) begin
          if (cnt == pass_q - LW'(1)) begin
            cnt_next = '0;
            if (pad_q != '0) st_next = PAD;
            else begin
              st_next   = WAIT;
              done_next = 1'b1;
            end
          end else begin
            cnt_next = cnt + LW'(1);
          end
        end
      end
      PAD: begin
        if (out_hs) begin
          if (cnt == pad_q - LW'(1)) begin
            cnt_next  = '0;
            st_next   = WAIT;
            done_next = 1'b1;
          end else begin
            cnt_next = cnt + LW'(1);
          end
        end
      end
      default: begin
        st_next  = WAIT;
        cnt_next = '0;
      end
    endcase
  end

  assign state = st;
  assign busy  = (st != WAIT);
  assign done  = done_q;
  assign odata = (st == PAD) ? PAD_VALUE : idata;

`ifdef FRAME_SEQ_SC_CNT_EN
  // frame_cnt steps on the same edge that raises done; drop_cnt saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (done_next) frame_cnt <= frame_cnt + 16'd1;
      if (in_hs && (st == FILL || st == PAD) && drop_cnt != '1)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_seq_sc.sv
// Randomized self-checking bench for frame_seq_sc with a behavioural plug and frame model.
// Checks frame_cnt/drop_cnt as well when FRAME_SEQ_SC_CNT_EN is defined.
module tb_frame_seq_sc;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam logic [DW-1:0] PADV = 32'h0;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [LW-1:0] skip_len, pass_len, pad_len;
  logic          ivalid, iready, ovalid, oready;
  logic [DW-1:0] idata, odata;
  logic [3:0]    state;
  logic          busy, done;
`ifdef FRAME_SEQ_SC_CNT_EN
  logic [15:0]   frame_cnt, drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] seq;
  logic [DW-1:0] last_outs[$];
  int exp_frames = 0;
  int exp_drops  = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream plug
  assign iready = state[0] ? 1'b1 : ((state[1] | state[2]) ? oready : 1'b0);
  assign ovalid = state[1] ? ivalid : state[2];

  frame_seq_sc #(.DW(DW), .LW(LW), .PAD_VALUE(PADV)) dut (
    .clk(clk), .rst(rst), .start(start),
    .skip_len(skip_len), .pass_len(pass_len), .pad_len(pad_len),
    .ivalid(ivalid), .iready(iready), .ovalid(ovalid), .oready(oready),
    .idata(idata), .state(state), .odata(odata), .busy(busy),
`ifdef FRAME_SEQ_SC_CNT_EN
    .done(done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`else
    .done(done)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef FRAME_SEQ_SC_CNT_EN
    check({tag, "_frame_cnt"}, frame_cnt, 64'(exp_frames));
    check({tag, "_drop_cnt"}, drop_cnt, 64'(exp_drops));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One frame: lengths, valid/ready percentages; abort_at>0 resets after that many outputs
  task automatic run_frame(input int sk, input int ps, input int pd,
                           input int vp, input int rp, input int abort_at,
                           output int n_cons);
    logic [DW-1:0] cons[$];
    logic [DW-1:0] outs[$];
    logic [DW-1:0] e;
    logic [3:0] first;
    int budget;
    bit fin;
    fin = 0;
    check("idle_busy", busy, 0);
    start = 1'b1;
    skip_len = LW'(sk); pass_len = LW'(ps); pad_len = LW'(pd);
    ivalid = 1'b0; oready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    first = (sk != 0) ? 4'b0001 : (ps != 0) ? 4'b0010 : (pd != 0) ? 4'b0100 : 4'b1000;
    check("first_state", state, first);
    check("first_done", done, (sk == 0 && ps == 0 && pd == 0));
    if (sk == 0 && ps == 0 && pd == 0) fin = 1;
    budget = 30 * (sk + ps + pd) + 50;
    while (!fin && budget > 0) begin
      ivalid = (int'($urandom_range(99)) < vp);
      oready = (int'($urandom_range(99)) < rp);
      idata  = seq;
      #1;
      if (ivalid && iready) begin
        cons.push_back(idata);
        seq = seq + 1;
      end
      if (ovalid && oready) outs.push_back(odata);
      @(negedge clk);
      budget--;
      if (abort_at > 0 && outs.size() == abort_at) begin
        rst = 1'b1; ivalid = 1'b0; oready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0; exp_drops = 0;
        check("abort_state", state, 4'b1000);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        check("abort_done_after", done, 0);
        check_counters("abort");
        n_cons = cons.size();
        return;
      end
      if (done) fin = 1;
    end
    ivalid = 1'b0; oready = 1'b0;
    check("frame_timeout", fin, 1);
    check("end_state", state, 4'b1000);
    check("end_busy", busy, 0);
    check("out_count", outs.size(), ps + pd);
    check("cons_min", (cons.size() >= sk + ps), 1);
    for (int k = 0; k < outs.size(); k++) begin
      if (k < ps) e = (sk + k < cons.size()) ? cons[sk + k] : '1;
      else        e = PADV;
      check("out_word", outs[k], e);
    end
    @(negedge clk);
    check("done_width", done, 0);
    exp_frames++;
    exp_drops += cons.size() - ps;
    check_counters("frame");
    last_outs = outs;
    n_cons = cons.size();
  endtask

  initial begin
    int nc, nd, last, cyc;
    rst = 1'b1; start = 1'b1;
    skip_len = 16'd3; pass_len = 16'd3; pad_len = 16'd3;
    ivalid = 1'b0; oready = 1'b0; idata = '0;
    seq = 32'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_state", state, 4'b1000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    check("rst_start_ignored", state, 4'b1000);
    check_counters("rst");

    // Worked example: 1..10 in, expect 3,4,5,pad,pad and 7 words consumed
    seq = 32'd1;
    run_frame(2, 3, 2, 100, 100, 0, nc);
    check("ex_consumed", nc, 7);
    check("ex_len", last_outs.size(), 5);
    if (last_outs.size() == 5) begin
      check("ex_w0", last_outs[0], 3);
      check("ex_w1", last_outs[1], 4);
      check("ex_w2", last_outs[2], 5);
      check("ex_w3", last_outs[3], 0);
      check("ex_w4", last_outs[4], 0);
    end

    seq = $urandom;
    run_frame(0, 4, 0, 100, 50, 0, nc);
    run_frame(0, 0, 0, 100, 100, 0, nc);
    check("zero_consumed", nc, 0);

    run_frame(0, 5, 0, 100, 100, 1, nc);
    seq = $urandom;
    run_frame(0, 2, 0, 80, 80, 0, nc);

    // start held high: three back-to-back frames, one WAIT cycle apart
    @(negedge clk);
    start = 1'b1; skip_len = 16'd1; pass_len = 16'd2; pad_len = 16'd1;
    ivalid = 1'b1; oready = 1'b1; idata = 32'hA5A5_0000;
    nd = 0; last = 0; cyc = 0;
    while (nd < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        nd++;
        if (nd == 1) check("b2b_first", cyc, 5);
        else         check("b2b_gap", cyc - last, 5);
        last = cyc;
        if (nd == 3) start = 1'b0;
      end
    end
    check("b2b_dones", nd, 3);
    @(negedge clk);
    ivalid = 1'b0; oready = 1'b0;
    check("b2b_state", state, 4'b1000);
    exp_frames += 3;
    exp_drops  += 6;
    check_counters("b2b");

    for (int i = 0; i < 12; i++) begin
      seq = $urandom;
      run_frame(int'($urandom_range(4)), int'($urandom_range(5)), int'($urandom_range(4)),
                int'($urandom_range(100, 40)), int'($urandom_range(100, 40)), 0, nc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_seq_sc.md
Name: frame_seq_sc

Overview:
- Sequencer placed directly upstream of the one-hot handshake plug. It drives the plug's 4-bit `state` input and the data mux, and turns one stream into one framed output per `start`.
- Each frame has three phases: skip `skip_len` leading input words, then pass `pass_len` words unchanged, then emit `pad_len` pad words.
- It tracks progress by watching the handshakes on both sides of the plug. It never drives `iready` or `ovalid` itself.

Parameters:
- DW, 32, data width.
- LW, 16, width of each length field and of the phase counter.
- PAD_VALUE, 0, constant driven on `odata` during the pad phase.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in WAIT.
- skip_len  in  LW  number of input words to discard; latched when `start` is accepted.
- pass_len  in  LW  number of words to pass through; latched when `start` is accepted.
- pad_len  in  LW  number of pad words to emit; latched when `start` is accepted.
- ivalid  in  1  upstream valid (monitored).
- iready  in  1  plug's `iready` (monitored).
- ovalid  in  1  plug's `ovalid` (monitored).
- oready  in  1  downstream ready (monitored).
- idata  in  DW  upstream data.
- state  out  4  one-hot state to the plug.
- odata  out  DW  data toward downstream.
- busy  out  1  high whenever the state is not WAIT.
- done  out  1  one-cycle pulse on the final handshake of a frame.

Behaviour:
- State encodings: FILL = 4'b0001 (skip phase), PASS = 4'b0010, PAD = 4'b0100, WAIT = 4'b1000. The plug blocks both sides in WAIT.
- Reset values: state = WAIT, counter = 0, latched lengths = 0, busy = 0, done = 0.
- Handshake events:
  - in_hs = ivalid & iready.
  - out_hs = ovalid & oready.
- WAIT:
  - On `start`, latch all three lengths and go to the first phase with a non-zero length, in the order FILL, PASS, PAD. Load counter = 0.
  - If all three lengths are 0: stay in WAIT, pulse `done` in the next cycle, and set busy = 0.
  - `start` is ignored outside WAIT.
- FILL: each in_hs increments the counter. When in_hs occurs with counter == skip_len-1, go to the next non-zero phase (PASS, else PAD, else WAIT) and reset the counter to 0.
- PASS: each out_hs increments the counter. When out_hs occurs with counter == pass_len-1, go to PAD if pad_len != 0, else to WAIT.
- PAD:
  - Each out_hs increments the counter. When out_hs occurs with counter == pad_len-1, go to WAIT.
  - Input words present during PAD are consumed and dropped, because the plug sets iready = oready in this state.
- done:
  - Asserted in the cycle after the handshake that causes the transition into WAIT; deasserted the following cycle.
  - Also asserted in the zero-length case described under WAIT.
- odata:
  - Combinational: PAD_VALUE when state == PAD, otherwise `idata`.
  - No added latency. The block adds zero pipeline stages.
- Lengths: unsigned. The maximum frame phase is 2^LW-1 words. The counter never wraps within a phase.
- Reset mid-frame: return to WAIT immediately and abandon partial counts. No `done` pulse.
- `start` held high: a new frame begins on the first WAIT cycle after the previous frame's transition into WAIT, which is the same cycle `done` is high. Back-to-back frames therefore leave exactly one WAIT cycle between them.

Optional Feature:
- Macro: FRAME_SEQ_SC_CNT_EN.
- When defined:
  - Adds output port `frame_cnt`, 16 bits, reset to 0.
  - `frame_cnt` increments on each `done` pulse, including zero-length frames.
  - It wraps from 16'hFFFF to 0.
  - Adds output port `drop_cnt`, 16 bits, reset to 0. It counts in_hs events in FILL and PAD and saturates at 16'hFFFF.
- When not defined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset with `rst` high for 2 cycles, then low -> state = 4'b1000, busy = 0, done = 0; `start` applied during reset is ignored.
- start with skip = 2, pass = 3, pad = 2, continuous valid/ready, idata = 1..10 -> downstream receives 3,4,5,0,0 (PAD_VALUE = 0); `done` pulses once; exactly 7 input words consumed.
- skip = 0, pass = 4, pad = 0 with random oready backpressure -> state goes straight to 4'b0010; 4 words are passed in order; WAIT is entered after the 4th out_hs.
- skip = 0, pass = 0, pad = 0 -> state stays 4'b1000; `done` pulses in the cycle after `start`; no handshakes are counted.
- `rst` asserted mid-PASS after 1 of 5 words -> WAIT next cycle, no `done`; a following frame with pass = 2 counts from 0 correctly.
- With FRAME_SEQ_SC_CNT_EN defined, 3 back-to-back frames with skip = 1, pad = 1 and input present during PAD -> frame_cnt = 3; drop_cnt = 6 (3 words in FILL plus 3 in PAD).
